noc_vc_credit_tracker: RTL
==========================

// Module: noc_vc_credit_tracker
// PURPOSE
//  Per-VC downstream credit and packet-lock tracker for one router output port.
//  Counts free flit slots in the downstream router's VC buffers and locks a VC for the duration of a packet.
//  Drives the vc_ready vector consumed by the port/VC arbitration controller.
//  Sits between the output port control and the link toward the neighbouring router.
// PARAMETERS
//  CHANNELS         Noc_VC_Channel  number of virtual channels (>=1)
//  DEPTH            4               downstream VC buffer depth in flits = initial credits per VC (>=1)
//  START_THRESHOLD  1               credits required on an idle VC before a new packet may start (1..DEPTH)
//  CW = $clog2(DEPTH+1) (localparam) credit counter width
// PORTS
//  noc_clk        in   1              clock
//  noc_rst_n      in   1              asynchronous active-low reset
//  i_clear        in   1              synchronous clear: same effect as reset
//  flit_valid     in   1              flit sent on the link this cycle
//  flit_vc        in   CHANNELS       one-hot VC of the sent flit
//  flit_sop       in   1              sent flit is head of packet
//  flit_eop       in   1              sent flit is tail of packet
//  credit_return  in   CHANNELS       per-VC credit returned by downstream this cycle (1 credit per bit)
//  vc_ready       out  CHANNELS       VC may accept a flit this cycle
//  vc_busy        out  CHANNELS       VC locked by a packet in flight
//  credit_count   out  CHANNELS*CW    current credit count per VC ([CHANNELS-1:0][CW-1:0])
// BEHAVIOUR
//  Clock noc_clk; reset asynchronous, active-low (noc_rst_n). All state is registered.
//  Reset/clear: every credit_count=DEPTH, every FSM=IDLE, vc_busy=0, vc_ready=1 (DEPTH>=START_THRESHOLD).
//  i_clear has priority over all other inputs in the same cycle.
//  send[i] = flit_valid & flit_vc[i] & onehot(flit_vc). Non-one-hot flit_vc with flit_valid: whole flit ignored.
//  Credit counter per VC, updated on the next edge:
//   send & !ret -> cnt-1; !send & ret -> cnt+1; send & ret -> unchanged.
//   Underflow (send with cnt==0 and no ret): saturates at 0. Overflow (ret with cnt==DEPTH and no send): saturates at DEPTH.
//  FSM per VC, states IDLE / BUSY:
//   IDLE -> BUSY on send & sop & !eop; IDLE stays on send & sop & eop (single-flit packet).
//   BUSY -> IDLE on send & eop. BUSY stays on body flits.
//   Protocol violations (send without sop in IDLE, send with sop in BUSY): FSM unchanged, credits still counted.
//  vc_ready[i] combinational from registered state only (no input->output path):
//   IDLE: credit_count >= START_THRESHOLD; BUSY: credit_count != 0.
//  vc_busy[i] = (state==BUSY). credit_count is the register value.
//  Latency: credit returned at cycle t -> visible in credit_count/vc_ready at t+1.
//   Flit sent at t with count 1 and no return -> vc_ready low at t+1.
//  VCs are fully independent; all VCs may update in the same cycle.
// CONFIGURATION
//  NOC_CREDIT_CHECK_EN defined: adds output err_o [CHANNELS-1:0]. Sticky per-VC error flag, cleared only by reset/i_clear.
//   Set by: underflow, overflow, or protocol violation on that VC.
//   A non-one-hot flit_vc with flit_valid sets every bit of err_o.
//   Flag visible the cycle after the event.
//  Macro undefined: port err_o absent; saturation and ignore behaviour identical; no checking logic.
// TESTING
//  Reset, CHANNELS=2, DEPTH=4 -> credit_count={4,4}, vc_ready=2'b11, vc_busy=0.
//  VC0: 4 flits sop..eop back-to-back, no returns -> counts 3,2,1,0; vc_ready[0] low after the 4th flit; busy high flits 1-3, low after eop.
//  VC0 count 0, credit_return[0] at t -> count 1 and vc_ready[0]=1 at t+1; simultaneous send+return at count 2 -> stays 2.
//  START_THRESHOLD=2, VC1 idle with count 1 -> vc_ready[1]=0; same count while BUSY -> vc_ready[1]=1.
//  Send on VC0 at count 0 -> count stays 0 (err_o[0]=1 with NOC_CREDIT_CHECK_EN); flit_vc=2'b11 -> no count change, err_o=2'b11.
//  i_clear mid-packet (VC0 BUSY, count 1) -> next cycle count 4, vc_busy[0]=0, err_o=0; async reset mid-packet gives same result.

Source files
------------

// File: rtl/noc_vc_credit_tracker.sv
// Per-VC downstream credit counter and packet lock for one router output port.
// Optional sticky error flags (err_o) are built when NOC_CREDIT_CHECK_EN is defined.
module noc_vc_credit_tracker #(
   parameter int unsigned CHANNELS        = 2,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned START_THRESHOLD = 1,
   localparam int unsigned CW             = $clog2(DEPTH + 1)
) (
   input  logic                         noc_clk,
   input  logic                         noc_rst_n,
   input  logic                         i_clear,
   input  logic                         flit_valid,
   input  logic [CHANNELS-1:0]          flit_vc,
   input  logic                         flit_sop,
   input  logic                         flit_eop,
   input  logic [CHANNELS-1:0]          credit_return,
   output logic [CHANNELS-1:0]          vc_ready,
   output logic [CHANNELS-1:0]          vc_busy,
   output logic [CHANNELS-1:0][CW-1:0]  credit_count
`ifdef NOC_CREDIT_CHECK_EN
   ,
   output logic [CHANNELS-1:0]          err_o
`endif
);

   typedef enum logic {StIdle, StBusy} state_e;

   localparam logic [CW-1:0] MaxCred = CW'(DEPTH);
   localparam logic [CW-1:0] StartCred = CW'(START_THRESHOLD);

   state_e                        r_state [CHANNELS];
   state_e                        w_state_nxt [CHANNELS];
   logic   [CHANNELS-1:0][CW-1:0] r_cnt;
   logic   [CHANNELS-1:0][CW-1:0] w_cnt_nxt;
   logic   [CHANNELS-1:0]         w_send;
   logic                          w_onehot;

   // A flit with a malformed VC select is dropped entirely.
   assign w_onehot = (flit_vc != '0) && ((flit_vc & (flit_vc - 1'b1)) == '0);

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_send[i]      = flit_valid & flit_vc[i] & w_onehot;
         w_cnt_nxt[i]   = r_cnt[i];
         w_state_nxt[i] = r_state[i];

         if (w_send[i] && !credit_return[i]) begin
            if (r_cnt[i] != '0) w_cnt_nxt[i] = r_cnt[i] - 1'b1;
         end else if (!w_send[i] && credit_return[i]) begin
            if (r_cnt[i] != MaxCred) w_cnt_nxt[i] = r_cnt[i] + 1'b1;
         end

         unique case (r_state[i])
            StIdle: if (w_send[i] && flit_sop && !flit_eop) w_state_nxt[i] = StBusy;
            StBusy: if (w_send[i] && !flit_sop && flit_eop) w_state_nxt[i] = StIdle;
            default: w_state_nxt[i] = StIdle;
         endcase
      end
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_cnt[i]   <= MaxCred;
            r_state[i] <= StIdle;
         end
      end else if (i_clear) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_cnt[i]   <= MaxCred;
            r_state[i] <= StIdle;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_cnt[i]   <= w_cnt_nxt[i];
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         vc_busy[i]      = (r_state[i] == StBusy);
         credit_count[i] = r_cnt[i];
         vc_ready[i]     = (r_state[i] == StBusy) ? (r_cnt[i] != '0) : (r_cnt[i] >= StartCred);
      end
   end

`ifdef NOC_CREDIT_CHECK_EN
   logic [CHANNELS-1:0] r_err;
   logic [CHANNELS-1:0] w_err_nxt;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_err_nxt[i] = r_err[i]
            | (w_send[i] & ~credit_return[i] & (r_cnt[i] == '0))
            | (~w_send[i] & credit_return[i] & (r_cnt[i] == MaxCred))
            | (w_send[i] & (r_state[i] == StIdle) & ~flit_sop)
            | (w_send[i] & (r_state[i] == StBusy) & flit_sop)
            | (flit_valid & ~w_onehot);
      end
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         r_err <= '0;
      end else if (i_clear) begin
         r_err <= '0;
      end else begin
         r_err <= w_err_nxt;
      end
   end

   assign err_o = r_err;
`else
   // Without checking, saturation and drop behaviour are unchanged; no flags are kept.
`endif

endmodule
